// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Constants and types shared by the PS/2 Set-2 key tracker.
//   - Protocol bytes: the break prefix, the extended prefix, the BAT result
//     codes and the overrun codes.
//   - Set-2 make codes for the game keys Z, X, C, V, B.
//   - ps2_state_t, the prefix-tracking state of the decoder.
//   - is_reset_code(), which flags the bytes that force the tracker back to
//     a clean state.
// ----------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK   = 8'hF0;
    localparam logic [7:0] PS2_EXT     = 8'hE0;
    localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
    localparam logic [7:0] PS2_BAT_ERR = 8'hFC;
    localparam logic [7:0] PS2_OVR0    = 8'h00;
    localparam logic [7:0] PS2_OVR1    = 8'hFF;

    localparam logic [7:0] SC_Z = 8'h1A;
    localparam logic [7:0] SC_X = 8'h22;
    localparam logic [7:0] SC_C = 8'h21;
    localparam logic [7:0] SC_V = 8'h2A;
    localparam logic [7:0] SC_B = 8'h32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_t;

    // A keyboard self-test result or an overrun means the held-key picture
    // can no longer be trusted, so these bytes flush the tracker.
    function automatic logic is_reset_code(input logic [7:0] code);
        return (code == PS2_BAT_OK)  || (code == PS2_BAT_ERR) ||
               (code == PS2_OVR0)    || (code == PS2_OVR1);
    endfunction

endpackage

// File: rtl/ps2_code_lookup.sv
// ----------------------------------------------------------------------------
// ps2_code_lookup
// Combinational byte-to-key matcher. Compares a scancode against every
// configured make code and returns the 1-based index of the lowest matching
// slot, plus the same result as a one-hot mask for the held-key register.
//
// Ports:
//   code    in   8         byte to classify
//   index   out  IDX_W     1-based matching key index, 0 when unmapped
//   onehot  out  NUM_KEYS  bit i set when key index i+1 matched, else 0
// ----------------------------------------------------------------------------
module ps2_code_lookup #(
    parameter int                    NUM_KEYS  = 5,
    parameter int                    IDX_W     = 4,
    parameter logic [NUM_KEYS*8-1:0] KEY_CODES = {8'h32, 8'h2A, 8'h21, 8'h22, 8'h1A}
) (
    input  logic [7:0]          code,
    output logic [IDX_W-1:0]    index,
    output logic [NUM_KEYS-1:0] onehot
);

    // Scanning from the top slot down lets the lowest matching slot
    // overwrite any higher match, which gives lowest-index priority when the
    // same code is configured twice.
    always_comb begin
        index  = '0;
        onehot = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (code == KEY_CODES[8*i +: 8]) begin
                index     = IDX_W'(i + 1);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// ----------------------------------------------------------------------------
// ps2_key_tracker
// PS/2 Set-2 scancode decoder for the game key-input path. Tracks break and
// extended prefixes, maps configured make codes to 1-based key indices,
// keeps a held-key mask, emits one-cycle press/release events and drops
// typematic repeats. A pending prefix that sees no follow-up byte within
// PREFIX_TIMEOUT cycles is abandoned.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no prefix pending; plain bytes are make codes
// BRK     | F0 seen; next byte is the released key
// EXT     | E0 seen; next byte is an extended (unmapped) key or F0
// EXT_BRK | E0 F0 seen; next byte is an extended release, discarded
//
// Ports:
//   clock        in   1         system clock
//   reset        in   1         synchronous, active-high reset
//   scan_code    in   8         byte from the PS/2 receive controller
//   scan_valid   in   1         one-cycle strobe qualifying scan_code
//   key_down     out  NUM_KEYS  bit i set while key index i+1 is held
//   any_pressed  out  1         OR of key_down
//   event_valid  out  1         one-cycle pulse on a mapped key change
//   event_make   out  1         with event_valid: 1 press, 0 release
//   event_index  out  IDX_W     with event_valid: 1-based key index, else 0
//   last_index   out  IDX_W     most recently pressed key while held, else 0
// ----------------------------------------------------------------------------
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int                    NUM_KEYS       = 5,
    parameter int                    IDX_W          = 4,
    parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = {SC_B, SC_V, SC_C, SC_X, SC_Z},
    parameter int                    PREFIX_TIMEOUT = 50000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          scan_code,
    input  logic                scan_valid,
    output logic [NUM_KEYS-1:0] key_down,
    output logic                any_pressed,
    output logic                event_valid,
    output logic                event_make,
    output logic [IDX_W-1:0]    event_index,
    output logic [IDX_W-1:0]    last_index
);

    localparam int               CNT_W     = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PREFIX_TIMEOUT - 1);

    ps2_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_KEYS-1:0] key_down_d;
    logic [IDX_W-1:0]    last_index_d;
    logic                event_valid_d;
    logic                event_make_d;
    logic [IDX_W-1:0]    event_index_d;

    logic [IDX_W-1:0]    hit_index;
    logic [NUM_KEYS-1:0] hit_onehot;
    logic                flush;
    logic                do_make;
    logic                do_break;

    ps2_code_lookup #(
        .NUM_KEYS  (NUM_KEYS),
        .IDX_W     (IDX_W),
        .KEY_CODES (KEY_CODES)
    ) u_lookup (
        .code   (scan_code),
        .index  (hit_index),
        .onehot (hit_onehot)
    );

    // Flush bytes override whatever prefix is pending.
    assign flush    = scan_valid && is_reset_code(scan_code);
    assign do_make  = scan_valid && !flush && (state_q == IDLE) &&
                      (scan_code != PS2_BREAK) && (scan_code != PS2_EXT);
    assign do_break = scan_valid && !flush && (state_q == BRK);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (scan_valid) begin
            if (flush) begin
                state_d = IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (scan_code == PS2_BREAK) begin
                            state_d = BRK;
                        end else if (scan_code == PS2_EXT) begin
                            state_d = EXT;
                        end
                    end
                    BRK:     state_d = IDLE;
                    EXT:     state_d = (scan_code == PS2_BREAK) ? EXT_BRK : IDLE;
                    EXT_BRK: state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end else if (state_q != IDLE) begin
            // A prefix whose follow-up byte was lost would otherwise turn the
            // next unrelated make into a break, so it is dropped quietly.
            if (cnt_q == CNT_LAST) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // --------------------------------------------------------------- output
    always_comb begin
        key_down_d    = key_down;
        last_index_d  = last_index;
        event_valid_d = 1'b0;
        event_make_d  = 1'b0;
        event_index_d = '0;
        if (flush) begin
            key_down_d   = '0;
            last_index_d = '0;
        end else if (do_make) begin
            // A make for a key already held is a typematic repeat.
            if ((hit_onehot != '0) && ((key_down & hit_onehot) == '0)) begin
                key_down_d    = key_down | hit_onehot;
                last_index_d  = hit_index;
                event_valid_d = 1'b1;
                event_make_d  = 1'b1;
                event_index_d = hit_index;
            end
        end else if (do_break) begin
            if ((key_down & hit_onehot) != '0) begin
                key_down_d    = key_down & ~hit_onehot;
                event_valid_d = 1'b1;
                event_index_d = hit_index;
                // No fallback to another held key: last_index only ever
                // names the key whose press was most recent.
                if (last_index == hit_index) begin
                    last_index_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_down    <= '0;
            last_index  <= '0;
            event_valid <= 1'b0;
            event_make  <= 1'b0;
            event_index <= '0;
        end else begin
            key_down    <= key_down_d;
            last_index  <= last_index_d;
            event_valid <= event_valid_d;
            event_make  <= event_make_d;
            event_index <= event_index_d;
        end
    end

    assign any_pressed = |key_down;

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Parametrised PS/2 Set-2 scancode decoder for the game's key-input path. It sits between the PS/2 receive controller (byte + strobe) and the game FSM. It tracks make/break/extended prefixes through a small FSM and maps up to NUM_KEYS configurable scancodes to 1-based key indices. It outputs a per-key held mask plus one-cycle press/release events, and filters typematic repeats.

Parameters:
NUM_KEYS, 5, number of mapped keys (1..15)
IDX_W, 4, width of key index outputs; must satisfy 2**IDX_W > NUM_KEYS
KEY_CODES, {8'h32,8'h2A,8'h21,8'h22,8'h1A}, packed NUM_KEYS*8 make codes; slice [8i+7:8i] is key index i+1 (default Z,X,C,V,B = 1..5)
PREFIX_TIMEOUT, 50000, clock cycles a pending prefix is held before being discarded (1 ms at 50 MHz)

Ports:
clock  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high reset
scan_code  in  8  received byte from PS/2 controller
scan_valid  in  1  one-cycle strobe; scan_code valid this cycle
key_down  out  NUM_KEYS  level mask; bit i = key index i+1 currently held
any_pressed  out  1  OR of key_down
event_valid  out  1  one-cycle pulse: a mapped key changed state
event_make  out  1  with event_valid: 1 = press, 0 = release
event_index  out  IDX_W  with event_valid: 1-based index; 0 when no event
last_index  out  IDX_W  index of most recently pressed key while it is still held, else 0

Behaviour:
- Clock and reset: single clock "clock"; reset is synchronous, active-high. Reset wins over scan_valid in the same cycle.
- Reset values: all outputs 0, FSM in IDLE, timeout counter 0.
- FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
- Transitions on scan_valid:
  - IDLE: F0 -> BRK. E0 -> EXT. Other codes are make codes: process make, stay IDLE.
  - BRK: any code -> process break, go to IDLE.
  - EXT: F0 -> EXT_BRK. Any other code -> discard (extended keys are unmapped), go to IDLE.
  - EXT_BRK: any code -> discard, go to IDLE.
- Reset codes: in any state, AA (BAT pass), FC (BAT fail), 00 or FF (overrun) clear key_down and last_index, go to IDLE, and produce no event.
- Lookup: compare scan_code against every KEY_CODES slice. The lowest matching index wins; no match gives index 0 (ignored).
- Make: if the matched key is not already down, set its key_down bit, pulse event_valid with event_make=1 and event_index=k, and set last_index=k. If the key is already down (typematic repeat), do nothing.
- Break: if the matched key is down, clear its bit and pulse event_valid with event_make=0 and event_index=k. If last_index==k, last_index becomes 0; there is no fallback to other held keys. A break of a key that is not down is ignored.
- Latency: outputs register on the clock edge that samples scan_valid. event_valid is high for exactly that one following cycle; event_index and event_make return to 0 afterwards.
- Throughput: one byte per cycle; back-to-back strobes are legal.
- Timeout: in BRK, EXT or EXT_BRK, the counter increments each cycle without scan_valid. On reaching PREFIX_TIMEOUT-1 the FSM returns to IDLE with no event. The counter clears on any scan_valid and in IDLE.
- Widths: counter width is $clog2(PREFIX_TIMEOUT+1). Indices are zero-extended to IDX_W.
- Reset mid-sequence: a pending prefix is lost, so the next byte is treated as a make.

Decomposition:
- Shared package ps2_pkg holds:
  - constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_BAT_OK=8'hAA, PS2_BAT_ERR=8'hFC, PS2_OVR0=8'h00, PS2_OVR1=8'hFF
  - Set-2 codes SC_Z=1A, SC_X=22, SC_C=21, SC_V=2A, SC_B=32
  - state enum ps2_state_t {IDLE,BRK,EXT,EXT_BRK}
- One sub-module, ps2_code_lookup: a combinational, parametrised (NUM_KEYS, IDX_W, KEY_CODES) byte-to-index priority matcher. The FSM, mask and timeout stay in the top.

Test Plan:
- Reset, then 1A -> event_valid 1 cycle, event_make=1, event_index=1, key_down=00001, last_index=1; then F0,1A -> event_make=0, index=1, key_down=0, last_index=0.
- 22,22,22 (typematic) -> exactly one event (index 2); key_down=00010.
- 1A, 32, F0,1A -> key_down=10000, last_index=5 unchanged by release of key 1; events idx1 make, idx5 make, idx1 break.
- E0,1A, then E0,F0,1A, then 1C (unmapped) -> no events, key_down unchanged, FSM ends IDLE.
- F0, then idle PREFIX_TIMEOUT cycles, then 21 -> treated as make: index 3 press event.
- Keys 1,3 held, then AA -> key_down=0, last_index=0, no event; reset asserted together with scan_valid=1A -> all outputs 0.
